reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 always reads 0 and writes to it are discarded.
REQ-004 SHALL have port CLK  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1: synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-006 SHALL have port IN  input  DATA_W: write data.
REQ-007 SHALL have port INADDRESS  input  ADDR_W: write address.
REQ-008 SHALL have port WRITE  input  1: write enable.
REQ-009 SHALL have port OUT1ADDRESS  input  ADDR_W: read port 1 address.
REQ-010 SHALL have port OUT2ADDRESS  input  ADDR_W: read port 2 address.
REQ-011 SHALL have port CLEAR  input  1: request for a sequential clear sweep of all registers.
REQ-012 SHALL have port OUT1  output  DATA_W: read port 1 data.
REQ-013 SHALL have port OUT2  output  DATA_W: read port 2 data.
REQ-014 SHALL have port BUSY  output  1: high while a clear sweep is in progress.
REQ-015 SHALL have port DROPPED  output  1: registered, one-cycle pulse flagging a write discarded because of a sweep.

Function
REQ-016 SHALL store DEPTH registers of DATA_W bits and have no explicit # delays.
REQ-017 SHALL, in IDLE with WRITE=1 at a rising edge, load IN into register INADDRESS at that edge.
REQ-018 SHALL drive OUT1/OUT2 combinationally from the addressed register with zero-cycle latency.
REQ-019 SHALL bypass in IDLE: if WRITE=1 and INADDRESS equals a read address, that port outputs IN in the same cycle.
REQ-020 SHALL, when ZERO_REG=1, drive 0 on any port addressing register 0, overriding bypass, and never modify register 0 on write.
REQ-021 SHALL implement a two-state FSM: IDLE and SWEEP.
REQ-022 SHALL transition IDLE->SWEEP on a rising edge with CLEAR=1, setting sweep pointer PTR=0; that same edge performs no write.
REQ-023 SHALL, at each rising edge in SWEEP, clear register PTR to 0 and increment PTR; after clearing DEPTH-1, return to IDLE, taking exactly DEPTH cycles.
REQ-024 SHALL hold BUSY=1 exactly while the FSM is in SWEEP, registered from state.
REQ-025 SHALL ignore CLEAR while in SWEEP; a sweep is not restarted or extended.
REQ-026 SHALL discard WRITE in SWEEP and on the IDLE->SWEEP edge, and assert DROPPED for the cycle after each discarded write.
REQ-027 SHALL disable bypass in SWEEP; reads return stored contents, so cleared entries read 0 and uncleared entries read old data.
REQ-028 SHALL hold DROPPED=0 in all other cycles.

Reset
REQ-029 SHALL, at a rising edge with RESET=0, clear all registers to 0, force IDLE, PTR=0, BUSY=0 and DROPPED=0.
REQ-030 SHALL give RESET priority over CLEAR and WRITE, including when RESET is asserted mid-sweep.
REQ-031 SHALL make OUT1/OUT2 read 0 after reset until a write occurs.

Verification (DATA_W=8, ADDR_W=3)
REQ-032 SHALL cover this scenario: RESET=0 for one edge, then read addresses 0 and 4 -> OUT1=0, OUT2=0, BUSY=0.
REQ-033 SHALL cover this scenario: write 95 to r2 and read r2 on port 1 in the same cycle -> OUT1=95 before the edge (bypass) and after it.
REQ-034 SHALL cover this scenario: ZERO_REG=1, write 28 to r0 -> OUT1 reads 0 before and after the edge.
REQ-035 SHALL cover this scenario: write 6 to r4 and 15 to r7, then pulse CLEAR -> BUSY high for 8 cycles; r4 reads 0 from the 5th sweep edge onward; r7 reads 15 until the 8th edge and 0 after it; BUSY=0 after.
REQ-036 SHALL cover this scenario: write 50 to r1 during the sweep -> DROPPED=1 for one cycle and r1 stays 0 after the sweep.
REQ-037 SHALL cover this scenario: RESET=0 at the 3rd sweep cycle with r5=9 still uncleared -> next cycle BUSY=0, all reads 0, and a following write of 9 to r5 reads 9.

Source files
------------

// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, two read ports, sweep control and status.
interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic              CLEAR;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              BUSY;
  logic              DROPPED;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    input  OUT1, OUT2, BUSY, DROPPED
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    output OUT1, OUT2, BUSY, DROPPED
  );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port with same-cycle bypass, two async read ports,
// optional hard-wired zero register and a DEPTH-cycle sequential clear sweep.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  reg_file_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;
  logic              r_dropped;
  logic              w_do_write;
  logic              w_drop;
  logic              w_ptr_last;
  logic              w_bypass_en;
  logic [DATA_W-1:0] w_out1;
  logic [DATA_W-1:0] w_out2;

  assign w_ptr_last  = (r_ptr == {ADDR_W{1'b1}});
  assign w_bypass_en = (r_state == IDLE) && bus.WRITE;

  // Read mux: zero register wins over bypass, bypass wins over stored data.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              bypass_en,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if ((ZERO_REG != 0) && (addr == '0)) begin
      return '0;
    end else if (bypass_en && (waddr == addr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_do_write   = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.CLEAR) begin
          w_next_state = SWEEP;
          w_drop       = bus.WRITE;
        end else begin
          w_do_write = bus.WRITE && !((ZERO_REG != 0) && (bus.INADDRESS == '0));
        end
      end
      SWEEP: begin
        w_drop = bus.WRITE;
        if (w_ptr_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = SWEEP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The pointer runs only in SWEEP and wraps back to zero on the last cleared entry.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_busy    <= (w_next_state == SWEEP);
      r_dropped <= w_drop;
      if (r_state == SWEEP) begin
        r_ptr <= r_ptr + 1'b1;
      end else begin
        r_ptr <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == SWEEP) begin
      r_mem[r_ptr] <= '0;
    end else if (w_do_write) begin
      r_mem[bus.INADDRESS] <= bus.IN;
    end
  end

  assign w_out1 = read_port(bus.OUT1ADDRESS, r_mem[bus.OUT1ADDRESS], w_bypass_en,
                            bus.INADDRESS, bus.IN);
  assign w_out2 = read_port(bus.OUT2ADDRESS, r_mem[bus.OUT2ADDRESS], w_bypass_en,
                            bus.INADDRESS, bus.IN);

  assign bus.OUT1    = w_out1;
  assign bus.OUT2    = w_out2;
  assign bus.BUSY    = r_busy;
  assign bus.DROPPED = r_dropped;
endmodule

// File: tb/tb_reg_file_param.sv
// Drives a plain and a zero-register instance with identical stimulus and checks both
// against an array-based reference model of the register file.
module tb_reg_file_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
    .CLK(clk), .RESET(rst_n), .bus(bus0)
  );
  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut1 (
    .CLK(clk), .RESET(rst_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Reference model: m_mem[0] is the plain file, m_mem[1] the zero-register file.
  logic [7:0] m_mem [2][8];
  int         m_left = 0;
  bit         m_drop = 1'b0;
  bit         c_wr, c_clr;
  logic [2:0] c_wa, c_a1, c_a2;
  logic [7:0] c_d;

  function automatic logic [7:0] exp_read(input int z, input logic [2:0] a);
    if (z == 1 && a == 3'd0) return 8'd0;
    if (m_left == 0 && c_wr && c_wa == a) return c_d;
    return m_mem[z][a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input bit clr, input logic [2:0] wa,
                      input logic [7:0] d, input logic [2:0] a1, input logic [2:0] a2,
                      input bit chk);
    @(negedge clk);
    rst_n = rst;
    c_wr = wr; c_clr = clr; c_wa = wa; c_d = d; c_a1 = a1; c_a2 = a2;
    bus0.WRITE = wr; bus0.CLEAR = clr; bus0.INADDRESS = wa; bus0.IN = d;
    bus0.OUT1ADDRESS = a1; bus0.OUT2ADDRESS = a2;
    bus1.WRITE = wr; bus1.CLEAR = clr; bus1.INADDRESS = wa; bus1.IN = d;
    bus1.OUT1ADDRESS = a1; bus1.OUT2ADDRESS = a2;
    #1;
    if (chk) begin
      check("dut0.OUT1", {24'd0, bus0.OUT1}, {24'd0, exp_read(0, a1)});
      check("dut0.OUT2", {24'd0, bus0.OUT2}, {24'd0, exp_read(0, a2)});
      check("dut1.OUT1", {24'd0, bus1.OUT1}, {24'd0, exp_read(1, a1)});
      check("dut1.OUT2", {24'd0, bus1.OUT2}, {24'd0, exp_read(1, a2)});
      check("dut0.BUSY", {31'd0, bus0.BUSY}, {31'd0, m_left > 0});
      check("dut1.BUSY", {31'd0, bus1.BUSY}, {31'd0, m_left > 0});
      check("dut0.DROPPED", {31'd0, bus0.DROPPED}, {31'd0, m_drop});
      check("dut1.DROPPED", {31'd0, bus1.DROPPED}, {31'd0, m_drop});
    end
    @(posedge clk);
    if (!rst) begin
      for (int z = 0; z < 2; z++) for (int i = 0; i < 8; i++) m_mem[z][i] = 8'd0;
      m_left = 0;
      m_drop = 1'b0;
    end else if (m_left > 0) begin
      m_drop = wr;
      m_mem[0][8 - m_left] = 8'd0;
      m_mem[1][8 - m_left] = 8'd0;
      m_left--;
    end else if (clr) begin
      m_drop = wr;
      m_left = 8;
    end else begin
      m_drop = 1'b0;
      if (wr) begin
        m_mem[0][wa] = d;
        if (wa != 3'd0) m_mem[1][wa] = d;
      end
    end
  endtask

  initial begin
    bus0.WRITE = 1'b0; bus0.CLEAR = 1'b0; bus0.IN = 8'd0; bus0.INADDRESS = 3'd0;
    bus0.OUT1ADDRESS = 3'd0; bus0.OUT2ADDRESS = 3'd0;
    bus1.WRITE = 1'b0; bus1.CLEAR = 1'b0; bus1.IN = 8'd0; bus1.INADDRESS = 3'd0;
    bus1.OUT1ADDRESS = 3'd0; bus1.OUT2ADDRESS = 3'd0;

    // Reset, then read r0 and r4.
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd4, 1'b1);
    check("reset.OUT2", {24'd0, bus0.OUT2}, 32'd0);

    // Bypass write of 95 to r2, then stored read.
    step(1'b1, 1'b1, 1'b0, 3'd2, 8'd95, 3'd2, 3'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd2, 3'd2, 1'b1);
    #1 check("r2.stored", {24'd0, bus0.OUT1}, 32'd95);

    // Write 28 to r0: the zero-register instance keeps reading 0.
    step(1'b1, 1'b1, 1'b0, 3'd0, 8'd28, 3'd0, 3'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b1);
    #1 check("zero.r0", {24'd0, bus1.OUT1}, 32'd0);

    // r4=6, r7=15, then a full sweep observed on both ports.
    step(1'b1, 1'b1, 1'b0, 3'd4, 8'd6, 3'd4, 3'd7, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd7, 8'd15, 3'd4, 3'd7, 1'b1);
    step(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 3'd4, 3'd7, 1'b1);
    for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd4, 3'd7, 1'b1);
    #1 check("sweep.r7", {24'd0, bus0.OUT2}, 32'd0);
    check("sweep.BUSY", {31'd0, bus0.BUSY}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd4, 3'd7, 1'b1);

    // Writes dropped on the entry edge and mid-sweep; r1 stays 0; CLEAR in SWEEP ignored.
    step(1'b1, 1'b1, 1'b1, 3'd3, 8'd77, 3'd1, 3'd3, 1'b1);
    for (int j = 0; j < 8; j++)
      step(1'b1, j == 3, j == 5, 3'd1, 8'd50, 3'd1, 3'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd1, 3'd3, 1'b1);
    check("drop.r1", {24'd0, bus0.OUT1}, 32'd0);

    // Reset on the third sweep cycle with r5=9 still uncleared.
    step(1'b1, 1'b1, 1'b0, 3'd5, 8'd9, 3'd5, 3'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 3'd5, 3'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd5, 3'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd5, 3'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd5, 3'd0, 1'b1);
    for (int a = 0; a < 8; a += 2)
      step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'(a), 3'(a + 1), 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd5, 8'd9, 3'd5, 3'd5, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd5, 3'd5, 1'b1);
    check("r5.after_reset", {24'd0, bus0.OUT1}, 32'd9);

    // Random traffic with occasional sweeps and resets.
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
           3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
